uart_tx_frame_gen: RTL

//   Parametrised UART transmitter, successor to the fixed one-clock-per-bit TX.

---
 rtl/uart_tx_frame_gen.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_frame_gen.sv
// UART TX: LSB-first frames, runtime parity (none/even/odd, word or per byte), 1/2 stop bits.
// tx_out falls on the accept edge; ready only in IDLE. `UART_TX_BREAK_EN adds break_req.
module uart_tx_frame_gen #(
   parameter int DATA_WIDTH   = 16,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid,
   input  logic [DATA_WIDTH-1:0] data,
   output logic                  ready,
   input  logic [1:0]            parity_mode,
   input  logic                  parity_per_byte,
   input  logic                  stop2,
   input  logic                  error_inject,
   output logic                  busy,
`ifdef UART_TX_BREAK_EN
   input  logic                  break_req,
`endif
   output logic                  tx_out
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
   localparam logic [IDX_W-1:0] BYTE_END = IDX_W'(7);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t                state;
   logic [CNT_W-1:0]      cnt;
   logic [IDX_W-1:0]      idx;
   logic [DATA_WIDTH-1:0] dat_q;
   logic                  par_en_q, par_odd_q, per_byte_q, stop2_q, inject_q;
   logic                  acc;
   logic                  stop_more;
   logic                  brk;

`ifdef UART_TX_BREAK_EN
   assign brk = break_req;
`else
   assign brk = 1'b0;
`endif

   logic [IDX_W-1:0] idx_nxt;
   logic             acc_nxt, par_here, par_bit, bit_end;

   // acc holds the XOR of data bits sent since the previous parity bit
   always_comb begin
      idx_nxt  = idx + 1'b1;
      acc_nxt  = acc ^ dat_q[idx];
      bit_end  = (cnt == CNT_LAST);
      par_here = par_en_q && ((idx == IDX_LAST) ||
                              (per_byte_q && ((idx & BYTE_END) == BYTE_END)));
      par_bit  = acc_nxt ^ par_odd_q ^ inject_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         idx        <= '0;
         dat_q      <= '0;
         par_en_q   <= 1'b0;
         par_odd_q  <= 1'b0;
         per_byte_q <= 1'b0;
         stop2_q    <= 1'b0;
         inject_q   <= 1'b0;
         acc        <= 1'b0;
         stop_more  <= 1'b0;
         tx_out     <= 1'b1;
         ready      <= 1'b1;
         busy       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               cnt <= '0;
               idx <= '0;
               acc <= 1'b0;
               if (brk) begin
                  tx_out <= 1'b0;
                  ready  <= 1'b0;
                  busy   <= 1'b1;
               end else if (!ready) begin
                  // break just released: line back high, accept from the next edge
                  tx_out <= 1'b1;
                  ready  <= 1'b1;
                  busy   <= 1'b0;
               end else if (valid) begin
                  dat_q      <= data;
                  par_en_q   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                  par_odd_q  <= (parity_mode == 2'b10);
                  per_byte_q <= parity_per_byte;
                  stop2_q    <= stop2;
                  inject_q   <= error_inject;
                  state      <= S_START;
                  tx_out     <= 1'b0;
                  ready      <= 1'b0;
                  busy       <= 1'b1;
               end else begin
                  tx_out <= 1'b1;
               end
            end
            S_START: begin
               cnt <= bit_end ? '0 : cnt + 1'b1;
               if (bit_end) begin
                  state  <= S_DATA;
                  tx_out <= dat_q[0];
               end
            end
            S_DATA: begin
               cnt <= bit_end ? '0 : cnt + 1'b1;
               if (bit_end) begin
                  if (par_here) begin
                     state  <= S_PARITY;
                     tx_out <= par_bit;
                     acc    <= 1'b0;
                  end else if (idx == IDX_LAST) begin
                     state     <= S_STOP;
                     tx_out    <= 1'b1;
                     stop_more <= stop2_q;
                  end else begin
                     idx    <= idx_nxt;
                     tx_out <= dat_q[idx_nxt];
                     acc    <= acc_nxt;
                  end
               end
            end
            S_PARITY: begin
               cnt <= bit_end ? '0 : cnt + 1'b1;
               if (bit_end) begin
                  if (idx == IDX_LAST) begin
                     state     <= S_STOP;
                     tx_out    <= 1'b1;
                     stop_more <= stop2_q;
                  end else begin
                     state  <= S_DATA;
                     idx    <= idx_nxt;
                     tx_out <= dat_q[idx_nxt];
                  end
               end
            end
            S_STOP: begin
               cnt <= bit_end ? '0 : cnt + 1'b1;
               if (bit_end) begin
                  if (stop_more) begin
                     stop_more <= 1'b0;
                  end else begin
                     state <= S_IDLE;
                     ready <= 1'b1;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state  <= S_IDLE;
               cnt    <= '0;
               tx_out <= 1'b1;
               ready  <= 1'b1;
               busy   <= 1'b0;
            end
         endcase
      end
   end
endmodule
